// File: rtl/dmem_if.sv
// Requester-side bundle for the shared data RAM arbiter.
// The master drives request fields; the slave returns grant and read data.
interface dmem_if #(
  parameter int ADDR_W = 11
);
  logic              req;
  logic              we;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req,
    output we,
    output wstrb,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  wstrb,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the CPU and the external port.
// CPU has priority; a wait counter bounds how long ext can be starved.
module dmem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  dmem_if.slave             io_cpu,
  dmem_if.slave             io_ext,
  output logic              o_ram_en,
  output logic [3:0]        o_ram_we,
  output logic [ADDR_W-3:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  localparam int         TAIL     = RAM_LAT - 1;

  logic [3:0]         r_wait_cnt;
  logic [RAM_LAT-1:0] r_vld;
  logic [RAM_LAT-1:0] r_own;

  logic w_force_ext;
  logic w_cpu_gnt;
  logic w_ext_gnt;
  logic w_rd_issue;
  logic w_tail_vld;
  logic w_cpu_rv;
  logic w_ext_rv;
  logic w_unused_lsb;

  assign w_force_ext = (r_wait_cnt == WAIT_MAX);

  assign w_cpu_gnt = ~i_rst & io_cpu.req
                   & ~(io_ext.req & w_force_ext);
  assign w_ext_gnt = ~i_rst & io_ext.req
                   & (~io_cpu.req | w_force_ext);

  assign w_rd_issue = (w_cpu_gnt & ~io_cpu.we)
                    | (w_ext_gnt & ~io_ext.we);

  assign w_unused_lsb = ^{io_cpu.addr[1:0],
                          io_ext.addr[1:0]};

  // Counts only contested cycles ext actually lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (w_ext_gnt | ~io_ext.req) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_MAX) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // {valid, owner} travels alongside the RAM read latency; 1 = ext.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld[0] <= w_rd_issue;
      r_own[0] <= w_ext_gnt;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_own[i] <= r_own[i-1];
      end
    end
  end

  assign w_tail_vld = r_vld[TAIL] & ~i_rst;
  assign w_cpu_rv   = w_tail_vld & ~r_own[TAIL];
  assign w_ext_rv   = w_tail_vld &  r_own[TAIL];

  assign io_cpu.gnt    = w_cpu_gnt;
  assign io_cpu.rvalid = w_cpu_rv;
  assign io_cpu.rdata  = w_cpu_rv ? i_ram_rdata : '0;

  assign io_ext.gnt    = w_ext_gnt;
  assign io_ext.rvalid = w_ext_rv;
  assign io_ext.rdata  = w_ext_rv ? i_ram_rdata : '0;

  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = '0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    unique case (1'b1)
      w_cpu_gnt: begin
        o_ram_en    = 1'b1;
        o_ram_we    = io_cpu.we ? io_cpu.wstrb : 4'b0;
        o_ram_addr  = io_cpu.addr[ADDR_W-1:2];
        o_ram_wdata = io_cpu.wdata;
      end
      w_ext_gnt: begin
        o_ram_en    = 1'b1;
        o_ram_we    = io_ext.we ? io_ext.wstrb : 4'b0;
        o_ram_addr  = io_ext.addr[ADDR_W-1:2];
        o_ram_wdata = io_ext.wdata;
      end
      default: begin
        o_ram_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-strobed RAM model
// and a scoreboard of expected read returns.
module tb_dmem_arbiter;

  localparam int AW  = 11;
  localparam int LAT = 2;
  localparam int MW  = 4;

  typedef struct {
    logic        own;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(AW)) cpu_b ();
  dmem_if #(.ADDR_W(AW)) ext_b ();

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-3:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  dmem_arbiter #(
    .ADDR_W  (AW),
    .RAM_LAT (LAT),
    .MAX_WAIT(MW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .io_cpu     (cpu_b),
    .io_ext     (ext_b),
    .o_ram_en   (ram_en),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  logic [31:0] mem [512];
  logic [31:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b])
          mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      if (ram_we == 4'b0)
        rd_pipe[0] <= mem[ram_addr];
    end
    for (int i = 1; i < LAT; i++)
      rd_pipe[i] <= rd_pipe[i-1];
  end

  assign ram_rdata = rd_pipe[LAT-1];

  logic [31:0] model [512];
  exp_t        q [$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic r, input logic w,
                         input logic [3:0] s,
                         input logic [AW-1:0] a,
                         input logic [31:0] d);
    cpu_b.req   = r;
    cpu_b.we    = w;
    cpu_b.wstrb = s;
    cpu_b.addr  = a;
    cpu_b.wdata = d;
  endtask

  task automatic set_ext(input logic r, input logic w,
                         input logic [3:0] s,
                         input logic [AW-1:0] a,
                         input logic [31:0] d);
    ext_b.req   = r;
    ext_b.we    = w;
    ext_b.wstrb = s;
    ext_b.addr  = a;
    ext_b.wdata = d;
  endtask

  task automatic record(input logic own, input logic we,
                        input logic [3:0] s,
                        input logic [AW-1:0] a,
                        input logic [31:0] d);
    logic [8:0] w;
    w = a[AW-1:2];
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      q.push_back('{own, model[w], cyc + LAT});
    end
  endtask

  task automatic check_ret();
    logic        ev;
    logic        own;
    logic [31:0] dat;
    ev  = (q.size() > 0) && (q[0].due == cyc);
    own = ev ? q[0].own : 1'b0;
    dat = ev ? q[0].data : 32'h0;
    chk("cpu_rvalid", 32'(cpu_b.rvalid), 32'(ev & ~own));
    chk("ext_rvalid", 32'(ext_b.rvalid), 32'(ev & own));
    chk("cpu_rdata", cpu_b.rdata, (ev & ~own) ? dat : 32'h0);
    chk("ext_rdata", ext_b.rdata, (ev & own) ? dat : 32'h0);
    if (ev) void'(q.pop_front());
  endtask

  // Checks the expected grants, books them, then advances one clock.
  task automatic commit(input logic ec, input logic ee);
    #1;
    chk("cpu_gnt", 32'(cpu_b.gnt), 32'(ec));
    chk("ext_gnt", 32'(ext_b.gnt), 32'(ee));
    chk("ram_en", 32'(ram_en), 32'(ec | ee));
    if (ec) record(1'b0, cpu_b.we, cpu_b.wstrb,
                   cpu_b.addr, cpu_b.wdata);
    if (ee) record(1'b1, ext_b.we, ext_b.wstrb,
                   ext_b.addr, ext_b.wdata);
    @(posedge clk);
    #1;
    cyc++;
    check_ret();
  endtask

  task automatic idle(input int n);
    set_cpu(0, 0, 4'h0, '0, '0);
    set_ext(0, 0, 4'h0, '0, '0);
    repeat (n) commit(0, 0);
  endtask

  initial begin
    rst = 1'b1;
    set_cpu(0, 0, 4'h0, '0, '0);
    set_ext(0, 0, 4'h0, '0, '0);
    @(posedge clk);
    #1;

    // requests during reset must be ignored
    set_cpu(1, 0, 4'h0, 11'h010, '0);
    set_ext(1, 1, 4'hF, 11'h7FC, 32'h1);
    #1;
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    commit(0, 0);
    commit(0, 0);
    rst = 1'b0;
    idle(1);

    set_ext(1, 1, 4'hF, 11'h010, 32'hA5A5_0010);
    commit(0, 1);
    set_ext(1, 1, 4'hF, 11'h7FC, 32'h1122_3344);
    commit(0, 1);
    set_ext(0, 0, 4'h0, '0, '0);
    set_cpu(1, 1, 4'hF, 11'h102, 32'h0BAD_CAFE);
    commit(1, 0);

    // single cpu read
    set_cpu(1, 0, 4'h0, 11'h010, '0);
    #1;
    chk("t1_ram_addr", 32'(ram_addr), 32'h004);
    chk("t1_ram_we", 32'(ram_we), 32'h0);
    commit(1, 0);
    idle(3);

    // partial ext write then immediate cpu read of the same word
    set_ext(1, 1, 4'b0011, 11'h7FC, 32'hDEAD_BEEF);
    #1;
    chk("t3_ram_we", 32'(ram_we), 32'h3);
    chk("t3_ram_addr", 32'(ram_addr), 32'h1FF);
    chk("t3_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    commit(0, 1);
    set_ext(0, 0, 4'h0, '0, '0);
    set_cpu(1, 0, 4'h0, 11'h7FE, '0);
    commit(1, 0);
    idle(3);

    // zero-strobe write still occupies the RAM but returns nothing
    set_ext(1, 1, 4'b0000, 11'h010, 32'hFFFF_FFFF);
    #1;
    chk("t0s_ram_we", 32'(ram_we), 32'h0);
    commit(0, 1);
    idle(3);

    // continuous contention
    set_cpu(1, 0, 4'h0, 11'h010, '0);
    set_ext(1, 0, 4'h0, 11'h7FC, '0);
    for (int i = 0; i < 12; i++)
      commit((i % 5) != 4, (i % 5) == 4);
    idle(1);

    // ext drops one cycle at wait_cnt=3
    set_cpu(1, 0, 4'h0, 11'h100, '0);
    set_ext(1, 0, 4'h0, 11'h010, '0);
    repeat (3) commit(1, 0);
    ext_b.req = 1'b0;
    commit(1, 0);
    ext_b.req = 1'b1;
    for (int i = 0; i < 5; i++)
      commit(i != 4, i == 4);
    idle(3);

    // alternating owners, pipelined returns
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        set_ext(0, 0, 4'h0, '0, '0);
        set_cpu(1, 0, 4'h0,
                (i % 4 == 0) ? 11'h010 : 11'h100, '0);
        commit(1, 0);
      end else begin
        set_cpu(0, 0, 4'h0, '0, '0);
        set_ext(1, 0, 4'h0,
                (i % 4 == 1) ? 11'h7FC : 11'h100, '0);
        commit(0, 1);
      end
    end
    idle(3);

    // reset with a read in flight and wait_cnt built up
    set_cpu(1, 0, 4'h0, 11'h010, '0);
    set_ext(1, 0, 4'h0, 11'h7FC, '0);
    repeat (3) commit(1, 0);
    rst = 1'b1;
    q.delete();
    #1;
    chk("rst2_ram_we", 32'(ram_we), 32'h0);
    commit(0, 0);
    commit(0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      commit(i != 4, i == 4);
    idle(4);
    chk("sb_empty", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
